// File: rtl/key_sequence_gen_pkg.sv
// key_seq_pkg: shared types and helpers for the key sequence generator.
package key_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    // All four push-button lines released (active-low).
    localparam logic [3:0] KEY_IDLE = 4'b1111;

    // Active-low one-hot: only the selected key line is pulled low.
    function automatic logic [3:0] key_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/key_sequence_gen_if.sv
// key_sequence_gen_if: controller-side handshake and KEY line bundle.
interface key_sequence_gen_if
    import key_seq_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) ();

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    start;
    logic                    abort;
    logic [2*NUM_DIGITS-1:0] code;
    logic [3:0]              key_n;
    logic                    busy;
    logic                    done;
    logic [IDX_W-1:0]        digit_idx;

    // The controller requests playback and watches progress.
    modport master (
        output start, abort, code,
        input  key_n, busy, done, digit_idx
    );

    // The generator plays the sequence onto the KEY lines.
    modport slave (
        input  start, abort, code,
        output key_n, busy, done, digit_idx
    );

endinterface

// File: rtl/key_sequence_gen_hold.sv
// hold_timer: loadable down-counter that stops at zero; expired while it reads 0.
module hold_timer #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/key_sequence_gen.sv
// key_sequence_gen: plays a captured multi-digit code as press/release pulses
// on the four active-low KEY lines, with start/busy/done handshake and abort.
module key_sequence_gen
    import key_seq_pkg::*;
#(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int NUM_DIGITS   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    key_sequence_gen_if.slave bus
);

    localparam int MAX_HOLD = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int TIMER_W  = $clog2(MAX_HOLD + 1);
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [TIMER_W-1:0] PRESS_LOAD = TIMER_W'(PRESS_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    seq_state_t              state;
    logic [2*NUM_DIGITS-1:0] code_q;
    logic [3:0]              key_q;
    logic                    busy_q;
    logic                    done_q;
    logic [IDX_W-1:0]        idx_q;

    logic                    timer_load;
    logic [TIMER_W-1:0]      timer_val;
    logic                    timer_expired;
    logic [IDX_W-1:0]        next_idx;
    logic [1:0]              next_digit;

    hold_timer #(
        .WIDTH (TIMER_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // Next digit to play, taken from the captured code rather than the live input.
    always_comb begin
        next_idx   = idx_q + 1'b1;
        next_digit = 2'(code_q >> (2 * int'(next_idx)));
    end

    // Reload the timer on exactly the edges where the FSM enters PRESS or GAP.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    timer_load = 1'b1;
                    timer_val  = PRESS_LOAD;
                end
            end
            PRESS: begin
                if (!bus.abort && timer_expired) begin
                    timer_load = 1'b1;
                    timer_val  = GAP_LOAD;
                end
            end
            GAP: begin
                if (!bus.abort && timer_expired && (idx_q != LAST_IDX)) begin
                    timer_load = 1'b1;
                    timer_val  = PRESS_LOAD;
                end
            end
            default: begin
            end
        endcase
    end

    // Playback FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            code_q <= '0;
            key_q  <= KEY_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    key_q  <= KEY_IDLE;
                    if (bus.start && !bus.abort) begin
                        code_q <= bus.code;
                        state  <= PRESS;
                        busy_q <= 1'b1;
                        idx_q  <= '0;
                        key_q  <= key_low(bus.code[1:0]);
                    end
                end
                PRESS: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        key_q  <= KEY_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                        idx_q  <= '0;
                    end else if (timer_expired) begin
                        state <= GAP;
                        key_q <= KEY_IDLE;
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        key_q  <= KEY_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                        idx_q  <= '0;
                    end else if (timer_expired) begin
                        if (idx_q == LAST_IDX) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            state <= PRESS;
                            idx_q <= next_idx;
                            key_q <= key_low(next_digit);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    key_q  <= KEY_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    idx_q  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.key_n     = key_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.digit_idx = idx_q;

endmodule

// File: tb/tb_key_sequence_gen.sv
// tb_key_sequence_gen: directed, table-driven bench for key_sequence_gen
// using the default timing (4 press, 4 gap, 4 digits, 32 cycles start->done).
module tb_key_sequence_gen;

    logic clk = 1'b0;
    logic rst_n;

    int checks = 0;
    int passed = 0;

    typedef struct {
        string       name;
        logic [7:0]  code;
        logic [15:0] exp_keys;
    } vec_t;

    vec_t vecs[4];

    key_sequence_gen_if #(.NUM_DIGITS(4)) bus ();

    key_sequence_gen #(
        .PRESS_CYCLES (4),
        .GAP_CYCLES   (4),
        .NUM_DIGITS   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic a, input logic [7:0] c);
        bus.start = s;
        bus.abort = a;
        bus.code  = c;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] ek, input logic eb,
                               input logic ed, input logic [1:0] ei);
        checks++;
        if (bus.key_n === ek && bus.busy === eb && bus.done === ed && bus.digit_idx === ei) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got key_n=%b busy=%b done=%b digit_idx=%0d, expected key_n=%b busy=%b done=%b digit_idx=%0d",
                     name, bus.key_n, bus.busy, bus.done, bus.digit_idx, ek, eb, ed, ei);
        end
    endtask

    // Expected outputs n edges after the accepting edge (n = 0 is the accept edge).
    function automatic logic [3:0] expKey(input logic [15:0] ek, input int n);
        if (n >= 32 || (n % 8) >= 4) return 4'b1111;
        return ek[4*(n/8) +: 4];
    endfunction

    function automatic logic [1:0] expIdx(input int n);
        if (n >= 32) return 2'd3;
        return 2'(n / 8);
    endfunction

    task automatic checkAt(input string name, input logic [15:0] ek, input int n);
        checkOutput($sformatf("%s n=%0d", name, n), expKey(ek, n), (n < 32), (n == 32), expIdx(n));
    endtask

    task automatic checkIdle(input string name);
        checkOutput(name, 4'b1111, 1'b0, 1'b0, 2'd0);
    endtask

    // Full playback; with disturb, start is re-pulsed and code changed mid-run and in DONE.
    task automatic playSequence(input string name, input logic [7:0] c, input logic [15:0] ek,
                                input bit disturb);
        int         falls;
        logic [3:0] prev;
        falls = 0;
        prev  = 4'b1111;
        applyStimulus(1'b1, 1'b0, c);
        for (int n = 0; n <= 32; n++) begin
            tick();
            checkAt(name, ek, n);
            falls += $countones(prev & ~bus.key_n);
            prev = bus.key_n;
            if (disturb && (n == 3 || n == 10 || n == 20 || n == 32))
                applyStimulus(1'b1, 1'b0, ~c);
            else
                applyStimulus(1'b0, 1'b0, disturb ? ~c : c);
        end
        tick();
        checkIdle($sformatf("%s after_done", name));
        applyStimulus(1'b0, 1'b0, c);
        tick();
        checkIdle($sformatf("%s idle", name));
        checks++;
        if (falls == 4) passed++;
        else $display("[TB] FAIL %s falling_edges: got %0d, expected 4", name, falls);
    endtask

    initial begin
        vecs[0].name = "code_2310"; vecs[0].code = 8'b00_01_11_10; vecs[0].exp_keys = {4'b1110, 4'b1101, 4'b0111, 4'b1011};
        vecs[1].name = "code_1111"; vecs[1].code = 8'h55;          vecs[1].exp_keys = {4'b1101, 4'b1101, 4'b1101, 4'b1101};
        vecs[2].name = "code_0123"; vecs[2].code = 8'hE4;          vecs[2].exp_keys = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
        vecs[3].name = "code_3210"; vecs[3].code = 8'h1B;          vecs[3].exp_keys = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Reset, then idle for 10 cycles.
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        tick();
        tick();
        checkIdle("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkIdle($sformatf("idle_after_reset %0d", i));
        end

        // Table-driven full playbacks.
        for (int v = 0; v < 4; v++) begin
            playSequence(vecs[v].name, vecs[v].code, vecs[v].exp_keys, 1'b0);
        end

        // Abort six cycles into playback, then confirm no done pulse and a clean restart.
        applyStimulus(1'b1, 1'b0, vecs[0].code);
        for (int n = 0; n <= 5; n++) begin
            tick();
            checkAt("abort_pre", vecs[0].exp_keys, n);
            applyStimulus(1'b0, (n == 5), vecs[0].code);
        end
        tick();
        checkIdle("abort_next");
        applyStimulus(1'b0, 1'b0, vecs[0].code);
        for (int i = 0; i < 30; i++) begin
            tick();
            checkIdle($sformatf("abort_quiet %0d", i));
        end
        playSequence("after_abort", vecs[0].code, vecs[0].exp_keys, 1'b0);

        // start re-pulsed and code changed while busy: original code plays out.
        playSequence("busy_restart", vecs[2].code, vecs[2].exp_keys, 1'b1);

        // Reset during the third press, with start and abort also asserted.
        applyStimulus(1'b1, 1'b0, vecs[3].code);
        for (int n = 0; n <= 17; n++) begin
            tick();
            checkAt("rst_pre", vecs[3].exp_keys, n);
            applyStimulus(1'b0, 1'b0, vecs[3].code);
        end
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, vecs[3].code);
        tick();
        checkIdle("mid_reset");
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b0, vecs[3].code);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkIdle($sformatf("post_reset %0d", i));
        end

        // start together with abort in IDLE: abort wins.
        applyStimulus(1'b1, 1'b1, vecs[1].code);
        tick();
        checkIdle("start_abort");
        applyStimulus(1'b0, 1'b0, vecs[1].code);
        for (int i = 0; i < 5; i++) begin
            tick();
            checkIdle($sformatf("start_abort_quiet %0d", i));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
